// File: rtl/opb_master_bridge.sv
// Single-word OPB bus master: turns fabric commands into OPB transfers and returns one response each.
// Optional local watchdog in the transfer phase is enabled by defining OPB_MASTER_WDOG_EN.
module opb_master_bridge #(
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter int unsigned C_MAX_RETRY   = 8,
  parameter int unsigned C_WDOG_CYCLES = 64
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
  input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
  input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
  output logic                        rsp_valid,
  output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
  output logic                        rsp_err,
  output logic                        M_request,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_seqAddr,
  output logic                        M_busLock,
  input  logic                        OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_timeout,
  input  logic                        OPB_toutSup
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StResp} state_e;

  state_e                      state_q, state_d;
  logic                        ready_q;
  logic                        rnw_q;
  logic [0:C_OPB_AWIDTH-1]     addr_q;
  logic [0:C_OPB_DWIDTH/8-1]   be_q;
  logic [0:C_OPB_DWIDTH-1]     wdata_q;
  logic [0:C_OPB_DWIDTH-1]     rdata_q, rdata_d;
  logic                        err_q, err_d;
  logic [7:0]                  retry_q, retry_d, retry_inc;
  logic                        accept;
  logic                        sel;
  logic                        wdog_hit;

`ifdef OPB_MASTER_WDOG_EN
  localparam int unsigned WdogW = $clog2(C_WDOG_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;

  // Held at zero outside the transfer phase so every select phase starts fresh.
  always_comb begin
    wdog_d = '0;
    if (state_q == StXfer) wdog_d = OPB_toutSup ? wdog_q : wdog_q + 1'b1;
  end

  assign wdog_hit = (state_q == StXfer) && !OPB_toutSup &&
                    (wdog_q == WdogW'(C_WDOG_CYCLES - 1));

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) wdog_q <= '0;
    else            wdog_q <= wdog_d;
  end
`else
  logic unused_tout_sup;
  assign unused_tout_sup = OPB_toutSup;
  assign wdog_hit        = 1'b0;
`endif

  assign retry_inc = retry_q + 8'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && ready_q) begin
          accept  = 1'b1;
          retry_d = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (OPB_MGrant) state_d = StXfer;
      end
      StXfer: begin
        if (OPB_errAck || OPB_timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else if (OPB_xferAck) begin
          if (rnw_q) rdata_d = OPB_DBus;
          state_d = StResp;
        end else if (OPB_retry) begin
          retry_d = retry_inc;
          if (retry_inc == 8'(C_MAX_RETRY)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ready_q <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      ready_q <= 1'b1;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      if (accept) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
      end
    end
  end

  // Outputs decode flops only; bus fields are forced to 0 when not selected (OR-bus).
  assign sel       = (state_q == StXfer);
  assign cmd_ready = ready_q && (state_q == StIdle);
  assign M_request = (state_q == StReq);
  assign M_select  = sel;
  assign M_RNW     = sel && rnw_q;
  assign M_ABus    = sel ? addr_q : '0;
  assign M_BE      = sel ? be_q : '0;
  assign M_DBus    = (sel && !rnw_q) ? wdata_q : '0;
  assign M_seqAddr = 1'b0;
  assign M_busLock = 1'b0;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
